// File: rtl/branch_operand_fwd.sv
// Forwarding unit for one branch-compare operand: picks the youngest in-flight result
// matching the source register, flags load-use hazards and registers the chosen operand.
module branch_operand_fwd #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 3,
    parameter int AW    = 5,
    parameter int CNT_W = 16,
    localparam int SW   = $clog2(NSRC + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 req_i,
    input  logic [AW-1:0]        rs_addr_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic [NSRC-1:0]      fwd_we_i,
    input  logic [NSRC-1:0]      fwd_rdy_i,
    input  logic [NSRC*AW-1:0]   fwd_addr_i,
    input  logic [NSRC*XLEN-1:0] fwd_data_i,
    output logic [XLEN-1:0]      operand_o,
    output logic [SW-1:0]        sel_o,
    output logic                 valid_o,
    output logic                 hazard_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    logic [NSRC-1:0] match;

    // x0 never forwards: a write to x0 is architecturally discarded.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_match
            assign match[gi] = fwd_we_i[gi]
                            && (fwd_addr_i[gi*AW +: AW] == rs_addr_i)
                            && (rs_addr_i != '0);
        end
    endgenerate

    logic [SW-1:0]   win_sel;
    logic [XLEN-1:0] win_data;
    logic            win_rdy;

    // Scan oldest to youngest so the youngest match overwrites all older ones.
    always_comb begin
        win_sel  = '0;
        win_data = rf_data_i;
        win_rdy  = 1'b1;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (match[k]) begin
                win_sel  = SW'(k + 1);
                win_data = fwd_data_i[k*XLEN +: XLEN];
                win_rdy  = fwd_rdy_i[k];
            end
        end
    end

    assign hazard_o = rst_n & req_i & ~win_rdy;

    logic [XLEN-1:0]  operand_q, operand_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        operand_d = operand_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        if (hazard_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!stall_i) begin
            operand_d = win_data;
            sel_d     = win_sel;
            valid_d   = req_i & ~hazard_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            operand_q <= operand_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign operand_o   = operand_q;
    assign sel_o       = sel_q;
    assign valid_o     = valid_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_operand_fwd.sv
// Directed bench for branch_operand_fwd: expected register state is modelled per cycle,
// queued when stimulus is applied and compared after the clock edge.
module tb_branch_operand_fwd;

    localparam int XLEN  = 32;
    localparam int NSRC  = 3;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             stall_i, flush_i, req_i;
    logic [AW-1:0]    rs_addr_i;
    logic [XLEN-1:0]  rf_data_i;
    logic [NSRC-1:0]  fwd_we_i, fwd_rdy_i;
    logic [AW-1:0]    fa [NSRC];
    logic [XLEN-1:0]  fd [NSRC];
    logic [NSRC*AW-1:0]   fwd_addr_i;
    logic [NSRC*XLEN-1:0] fwd_data_i;
    logic [XLEN-1:0]  operand_o;
    logic [1:0]       sel_o;
    logic             valid_o, hazard_o;
    logic [CNT_W-1:0] stall_cnt_o;

    assign fwd_addr_i = {fa[2], fa[1], fa[0]};
    assign fwd_data_i = {fd[2], fd[1], fd[0]};

    branch_operand_fwd #(.XLEN(XLEN), .NSRC(NSRC), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .req_i(req_i),
        .rs_addr_i(rs_addr_i), .rf_data_i(rf_data_i), .fwd_we_i(fwd_we_i),
        .fwd_rdy_i(fwd_rdy_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
        .operand_o(operand_o), .sel_o(sel_o), .valid_o(valid_o), .hazard_o(hazard_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]  op;
        logic [1:0]       sel;
        logic             v;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference selection: first matching source counting up from the youngest.
    task automatic model_pick(output int w, output logic [XLEN-1:0] d, output logic [1:0] s);
        w = -1;
        d = rf_data_i;
        s = 2'd0;
        if (rs_addr_i != 0) begin
            for (int k = 0; k < NSRC; k++) begin
                if (w < 0 && fwd_we_i[k] && fa[k] == rs_addr_i) begin
                    w = k;
                    d = fd[k];
                    s = 2'(k + 1);
                end
            end
        end
    endtask

    task automatic cycle(input string tag);
        int              w;
        logic [XLEN-1:0] d;
        logic [1:0]      s;
        logic            haz;
        exp_t            e;
        #1;
        model_pick(w, d, s);
        haz = req_i && (w >= 0) && !fwd_rdy_i[w];
        chk({tag, ".hazard"}, 32'(hazard_o), 32'(haz));
        if (haz && m.cnt != {CNT_W{1'b1}}) m.cnt = m.cnt + 1'b1;
        if (flush_i) begin
            m.v = 1'b0;
        end else if (!stall_i) begin
            m.op  = d;
            m.sel = s;
            m.v   = req_i && !haz;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".operand"}, operand_o, e.op);
        chk({tag, ".sel"}, 32'(sel_o), 32'(e.sel));
        chk({tag, ".valid"}, 32'(valid_o), 32'(e.v));
        chk({tag, ".cnt"}, 32'(stall_cnt_o), 32'(e.cnt));
        txn++;
        $display("txn %0d %s: op=%h sel=%0d valid=%0b cnt=%0d", txn, tag,
                 operand_o, sel_o, valid_o, stall_cnt_o);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".operand"}, operand_o, 32'd0);
        chk({tag, ".sel"}, 32'(sel_o), 32'd0);
        chk({tag, ".valid"}, 32'(valid_o), 32'd0);
        chk({tag, ".hazard"}, 32'(hazard_o), 32'd0);
        chk({tag, ".cnt"}, 32'(stall_cnt_o), 32'd0);
    endtask

    task automatic set_src(input int k, input logic we, input logic rdy,
                           input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        fwd_we_i[k]  = we;
        fwd_rdy_i[k] = rdy;
        fa[k] = a;
        fd[k] = d;
    endtask

    initial begin
        m = '0;
        rst_n = 1'b0;
        stall_i = 0; flush_i = 0;
        // A hazard-shaped input during reset must not raise hazard_o.
        req_i = 1; rs_addr_i = 5'd7; rf_data_i = 32'h0;
        fwd_we_i = '0; fwd_rdy_i = '0;
        for (int k = 0; k < NSRC; k++) begin fa[k] = '0; fd[k] = '0; end
        set_src(0, 1, 0, 5'd7, 32'h1);
        #2;
        check_zero("reset_init");
        #10 rst_n = 1'b1;
        set_src(0, 0, 0, 5'd0, 32'h0);

        // Youngest of two ready matches wins.
        rs_addr_i = 5'd5; rf_data_i = 32'h1234;
        set_src(0, 1, 1, 5'd5, 32'hAAAA);
        set_src(2, 1, 1, 5'd5, 32'hCCCC);
        cycle("prio_src0");
        set_src(0, 0, 1, 5'd5, 32'hAAAA);
        cycle("prio_src2");
        set_src(1, 1, 1, 5'd5, 32'hBBBB);
        cycle("prio_src1");
        rs_addr_i = 5'd9;
        cycle("no_match_rf");

        // x0 always reads the register file.
        rs_addr_i = 5'd0; rf_data_i = 32'h0;
        set_src(1, 1, 1, 5'd0, 32'hDEAD);
        cycle("x0_guard");

        // Load-use: younger unready match is not masked by an older ready one.
        rs_addr_i = 5'd7; rf_data_i = 32'h5555;
        set_src(0, 1, 0, 5'd7, 32'h7777);
        set_src(1, 1, 1, 5'd7, 32'h1111);
        set_src(2, 0, 0, 5'd0, 32'h0);
        cycle("loaduse_1");
        cycle("loaduse_2");
        cycle("loaduse_3");
        fwd_rdy_i[0] = 1'b1;
        cycle("loaduse_ready");
        req_i = 0; fwd_rdy_i[0] = 1'b0;
        cycle("noreq_nohaz");

        // Stall freezes registers while inputs move; counter still runs.
        req_i = 1; fwd_rdy_i[0] = 1'b1;
        cycle("pre_stall");
        stall_i = 1;
        rs_addr_i = 5'd3; rf_data_i = 32'h3333;
        cycle("stall_1");
        rs_addr_i = 5'd7; fwd_rdy_i[0] = 1'b0;
        cycle("stall_2_haz");
        fwd_rdy_i[0] = 1'b1; set_src(1, 1, 1, 5'd7, 32'h9999);
        cycle("stall_3");
        flush_i = 1;
        cycle("stall_flush");
        stall_i = 0; flush_i = 0;
        cycle("post_flush");
        flush_i = 1;
        cycle("flush_only");
        flush_i = 0;

        // Counter saturation under a sustained hazard.
        fwd_rdy_i[0] = 1'b0;
        for (int i = 0; i < 20; i++) cycle("saturate");
        fwd_rdy_i[0] = 1'b1;
        cycle("sat_release");

        // Asynchronous reset mid-run with valid_o high.
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        m = '0;
        #2 rst_n = 1'b1;
        cycle("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
